// File: rtl/rng_pool.sv
// Entropy pool: XOR-folds raw RNG cells, von Neumann debiases, runs a
// repetition-count health test and buffers OUT_WIDTH-bit words in a FIFO.
module rng_pool #(
  parameter int CHANNELS   = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int RCT_CUTOFF = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [CHANNELS-1:0]             raw_bits,
  input  logic                            health_clr,
  output logic [OUT_WIDTH-1:0]            rnd_data,
  output logic                            rnd_valid,
  input  logic                            rnd_ready,
  output logic                            health_fail,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(RCT_CUTOFF + 1);
  localparam int BW = $clog2(OUT_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FAIL} state_t;
  state_t state, state_nxt;

  logic [OUT_WIDTH-1:0] sreg;
  logic [BW-1:0]        bit_cnt;
  logic                 phase, a_bit, prev_f, pending;
  logic [CW-1:0]        rct_cnt, rct_nxt;

  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;

  logic                 f, full, pop, can_push, sample, trip, take, emit, word_done, push;
  logic [OUT_WIDTH-1:0] word_nxt, push_data;

  always_comb begin
    f        = ^raw_bits;
    full     = (level == LW'(FIFO_DEPTH));
    pop      = (level != '0) && rnd_ready;
    can_push = !full || pop;
    // A completed word that found the FIFO full waits in sreg and blocks sampling.
    sample   = (state == S_COLLECT) && enable && !pending;

    if (rct_cnt == '0 || f != prev_f)       rct_nxt = CW'(1);
    else if (rct_cnt == CW'(RCT_CUTOFF))    rct_nxt = rct_cnt;
    else                                    rct_nxt = rct_cnt + CW'(1);

    trip      = sample && (rct_nxt == CW'(RCT_CUTOFF));
    take      = sample && !trip;
    emit      = take && phase && (a_bit != f);
    word_nxt  = {sreg[OUT_WIDTH-2:0], a_bit};
    word_done = emit && (bit_cnt == BW'(OUT_WIDTH - 1));
    push      = ((word_done || pending) && can_push) && (state != S_FAIL);
    push_data = pending ? sreg : word_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (enable) state_nxt = S_COLLECT;
      S_COLLECT: if (trip) state_nxt = S_FAIL;
                 else if (!enable) state_nxt = S_IDLE;
      S_FAIL:    if (health_clr) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      a_bit   <= 1'b0;
      prev_f  <= 1'b0;
      rct_cnt <= '0;
      pending <= 1'b0;
    end else if (trip) begin
      sreg    <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      rct_cnt <= '0;
      pending <= 1'b0;
    end else begin
      if (take) begin
        prev_f  <= f;
        rct_cnt <= rct_nxt;
        phase   <= ~phase;
        if (!phase) a_bit <= f;
      end
      if (emit) begin
        if (word_done) begin
          bit_cnt <= '0;
          if (can_push) begin
            sreg <= '0;
          end else begin
            sreg    <= word_nxt;
            pending <= 1'b1;
          end
        end else begin
          sreg    <= word_nxt;
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
      if (pending && can_push) begin
        pending <= 1'b0;
        sreg    <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (trip) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign rnd_valid   = (level != '0);
  assign rnd_data    = rnd_valid ? mem[rd_ptr] : '0;
  assign health_fail = (state == S_FAIL);
  assign fifo_level  = level;

endmodule

// File: tb/tb_rng_pool.sv
// Scoreboard bench for rng_pool: stimulus queues expected words, a monitor
// compares every accepted word; status outputs are checked inline.
module tb_rng_pool;

  logic        clk = 1'b0;
  logic        rst, enable, health_clr, rnd_ready;
  logic [7:0]  raw_bits;
  logic [31:0] rnd_data;
  logic        rnd_valid, health_fail;
  logic [2:0]  fifo_level;

  int checks = 0;
  int failures = 0;
  int words_seen = 0;
  logic [31:0] exp_q[$];

  rng_pool #(.CHANNELS(8), .OUT_WIDTH(32), .RCT_CUTOFF(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .raw_bits(raw_bits),
    .health_clr(health_clr), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .health_fail(health_fail), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rnd_valid && rnd_ready) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got %h expected none", rnd_data);
      end else begin
        check("word", rnd_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] v);
    raw_bits = v;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; health_clr = 1'b0; raw_bits = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // IDLE -> COLLECT transition edge; raw_bits are not sampled on it
  task automatic start();
    enable = 1'b1;
    tick();
  endtask

  task automatic ones_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      sample(8'h01);
      sample(8'h00);
    end
  endtask

  task automatic zero_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      sample(8'h00);
      sample(8'h80);
    end
  endtask

  task automatic wait_empty(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int base;
    rnd_ready = 1'b0;
    do_reset();
    check("rst_valid", rnd_valid, 0);
    check("rst_data", rnd_data, 0);
    check("rst_hfail", health_fail, 0);
    check("rst_level", fifo_level, 0);

    // debiased ones
    rnd_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFFF);
    start();
    ones_pairs(31);
    sample(8'h01);
    check("ones_valid_63", rnd_valid, 0);
    sample(8'h00);
    check("ones_valid_64", rnd_valid, 1);
    check("ones_level_64", fifo_level, 1);
    check("ones_hfail", health_fail, 0);
    enable = 1'b0;
    tick();
    wait_empty(10);

    // debiased zeros
    do_reset();
    exp_q.push_back(32'h0000_0000);
    start();
    zero_pairs(32);
    enable = 1'b0;
    wait_empty(10);

    // discard and fold: 8'h03 pairs fold to 0,0 and emit nothing
    do_reset();
    w = 32'hA5C3_0F96;
    exp_q.push_back(w);
    start();
    for (int i = 31; i >= 0; i--) begin
      if (w[i]) begin sample(8'h01); sample(8'h00); end
      else      begin sample(8'h00); sample(8'h80); end
      sample(8'h03);
      sample(8'h03);
    end
    enable = 1'b0;
    wait_empty(10);

    // RCT trip from reset, health_clr on the trip edge ignored
    do_reset();
    rnd_ready = 1'b0;
    start();
    repeat (15) sample(8'h00);
    check("rct_15_hfail", health_fail, 0);
    health_clr = 1'b1;
    sample(8'h00);
    health_clr = 1'b0;
    check("rct_16_hfail", health_fail, 1);
    check("rct_16_valid", rnd_valid, 0);
    check("rct_16_level", fifo_level, 0);
    tick();
    check("rct_sticky", health_fail, 1);
    health_clr = 1'b1;
    tick();
    health_clr = 1'b0;
    check("rct_clr", health_fail, 0);
    tick();
    repeat (15) sample(8'h00);
    check("rct_resume_15", health_fail, 0);
    sample(8'h00);
    check("rct_resume_16", health_fail, 1);

    // trip flushes a buffered word
    health_clr = 1'b1;
    tick();
    health_clr = 1'b0;
    tick();
    ones_pairs(32);
    check("flush_pre_level", fifo_level, 1);
    check("flush_pre_valid", rnd_valid, 1);
    repeat (14) sample(8'h00);
    check("flush_14_hfail", health_fail, 0);
    check("flush_14_level", fifo_level, 1);
    sample(8'h00);
    check("flush_hfail", health_fail, 1);
    check("flush_level", fifo_level, 0);
    check("flush_valid", rnd_valid, 0);
    check("flush_data", rnd_data, 0);
    health_clr = 1'b1;
    enable = 1'b0;
    tick();
    health_clr = 1'b0;

    // backpressure: four buffered plus one pending, then drain
    do_reset();
    rnd_ready = 1'b0;
    start();
    ones_pairs(32);
    check("bp_level_1", fifo_level, 1);
    ones_pairs(96);
    check("bp_level_4", fifo_level, 4);
    ones_pairs(32);
    check("bp_level_pend", fifo_level, 4);
    ones_pairs(20);
    check("bp_level_stall", fifo_level, 4);
    check("bp_hfail", health_fail, 0);
    base = words_seen;
    repeat (5) exp_q.push_back(32'hFFFF_FFFF);
    rnd_ready = 1'b1;
    ones_pairs(10);
    rnd_ready = 1'b0;
    check("bp_drained", words_seen - base, 5);
    check("bp_queue", exp_q.size(), 0);
    check("bp_hfail_end", health_fail, 0);

    // asynchronous reset mid-word discards buffered and partial words
    do_reset();
    start();
    ones_pairs(32);
    ones_pairs(10);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", rnd_valid, 0);
    check("arst_data", rnd_data, 0);
    check("arst_level", fifo_level, 0);
    check("arst_hfail", health_fail, 0);
    enable = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    rnd_ready = 1'b1;
    exp_q.push_back(32'h0000_0000);
    start();
    zero_pairs(31);
    sample(8'h00);
    check("arst_valid_63", rnd_valid, 0);
    sample(8'h80);
    check("arst_valid_64", rnd_valid, 1);
    enable = 1'b0;
    wait_empty(10);

    check("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
